// File: rtl/control_unit.sv
// Multi-cycle sequencer for the 8-bit ALU: fetches from a synchronous ROM, decodes,
// drives the ALU operands and captures the result into the accumulator and carry flag.
module control_unit #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] instr_addr,
  input  logic [15:0]       instr_data,
  output logic [2:0]        alu_op,
  output logic [7:0]        alu_a,
  output logic [7:0]        alu_b,
  input  logic [7:0]        alu_out,
  input  logic              alu_cy,
  output logic [7:0]        acc,
  output logic              cy_flag,
  output logic              halted
);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    WB     = 3'd3,
    HALT   = 3'd4
  } state_t;

  localparam logic [3:0] OP_LDI = 4'h1;
  localparam logic [3:0] OP_MOV = 4'h2;
  localparam logic [3:0] OP_JMP = 4'h3;
  localparam logic [3:0] OP_JC  = 4'h4;
  localparam logic [3:0] OP_JZ  = 4'h5;
  localparam logic [3:0] OP_HLT = 4'h6;

  state_t            state_reg;
  logic [ADDR_W-1:0] pc_reg;
  logic [15:0]       ir_reg;
  logic [7:0]        regs_reg [4];

  logic [3:0]        opcode;
  logic              src_is_reg;
  logic [1:0]        reg_idx;
  logic [7:0]        imm;
  logic [ADDR_W-1:0] jump_target;
  logic              unused_ir_bit;

  assign opcode        = ir_reg[15:12];
  assign src_is_reg    = ir_reg[11];
  assign reg_idx       = ir_reg[9:8];
  assign imm           = ir_reg[7:0];
  assign jump_target   = imm[ADDR_W-1:0];
  assign unused_ir_bit = ir_reg[10];

  assign instr_addr = pc_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= FETCH;
      pc_reg    <= '0;
      ir_reg    <= '0;
      for (int i = 0; i < 4; i++) regs_reg[i] <= '0;
      alu_op    <= '0;
      alu_a     <= '0;
      alu_b     <= '0;
      acc       <= '0;
      cy_flag   <= 1'b0;
      halted    <= 1'b0;
    end else begin
      case (state_reg)
        FETCH: state_reg <= DECODE;

        DECODE: begin
          ir_reg    <= instr_data;
          pc_reg    <= pc_reg + ADDR_W'(1);
          state_reg <= EXEC;
        end

        EXEC: begin
          state_reg <= FETCH;
          if (opcode[3]) begin
            // Operands are registered here so the ALU settles for the whole WB cycle.
            alu_op    <= opcode[2:0];
            alu_a     <= acc;
            alu_b     <= src_is_reg ? regs_reg[reg_idx] : imm;
            state_reg <= WB;
          end else begin
            case (opcode)
              OP_LDI: acc <= imm;
              OP_MOV: regs_reg[reg_idx] <= acc;
              OP_JMP: pc_reg <= jump_target;
              OP_JC:  if (cy_flag) pc_reg <= jump_target;
              OP_JZ:  if (acc == 8'h00) pc_reg <= jump_target;
              OP_HLT: begin
                halted    <= 1'b1;
                state_reg <= HALT;
              end
              default: ;
            endcase
          end
        end

        WB: begin
          acc <= alu_out;
          // SUB and the two top ops keep the previous carry.
          case (alu_op)
            3'b000:                         cy_flag <= alu_cy;
            3'b010, 3'b011, 3'b100, 3'b101: cy_flag <= 1'b0;
            default: ;
          endcase
          state_reg <= FETCH;
        end

        HALT: ;

        default: state_reg <= FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: an instruction-level reference model fills a scoreboard
// with the expected architectural state at every instruction boundary.
module tb_control_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  instr_addr;
  logic [15:0] instr_data;
  logic [2:0]  alu_op;
  logic [7:0]  alu_a, alu_b, alu_out, acc;
  logic        alu_cy, cy_flag, halted;

  always #5 clk = ~clk;

  control_unit #(.ADDR_W(8)) dut (
    .clk(clk), .rst(rst),
    .instr_addr(instr_addr), .instr_data(instr_data),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
    .alu_out(alu_out), .alu_cy(alu_cy),
    .acc(acc), .cy_flag(cy_flag), .halted(halted)
  );

  // Environment ALU: returns {carry, result}.
  function automatic logic [8:0] alu_f(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      3'd0: return {1'b0, a} + {1'b0, b};
      3'd1: return {1'b0, a} - {1'b0, b};
      3'd2: return {1'b0, a & b};
      3'd3: return {1'b0, a | b};
      3'd4: return {1'b0, a ^ b};
      3'd5: return {1'b0, ~a};
      3'd6: return {a[7], a[6:0], 1'b0};
      default: return {a[0], 1'b0, a[7:1]};
    endcase
  endfunction

  logic [15:0] rom [256];
  always @(posedge clk) instr_data <= rom[instr_addr];
  assign {alu_cy, alu_out} = alu_f(alu_op, alu_a, alu_b);

  typedef struct {
    int         wt;
    int         tag;
    logic [7:0] pc;
    logic [7:0] acc;
    logic       cy;
    logic       hlt;
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
  } rec_t;

  rec_t q[$];
  event pushed_ev;
  bit   busy = 1'b0;
  int   n_checks = 0;
  int   n_pass = 0;

  task automatic push(input int wt, input int tag, input logic [7:0] pc, input logic [7:0] ac,
                      input logic cy, input logic hl, input logic [2:0] op,
                      input logic [7:0] a, input logic [7:0] b);
    rec_t r;
    r.wt = wt; r.tag = tag; r.pc = pc; r.acc = ac; r.cy = cy; r.hlt = hl;
    r.op = op; r.a = a; r.b = b;
    q.push_back(r);
  endtask

  task automatic chk(input string nm, input int tag, input logic [7:0] got, input logic [7:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s rec %0d: got %h expected %h", nm, tag, got, want);
  endtask

  // Monitor: each record says how many falling edges after the previous one it applies.
  initial begin
    rec_t r;
    forever begin
      if (q.size() == 0) @(pushed_ev);
      busy = 1'b1;
      r = q.pop_front();
      repeat (r.wt) @(negedge clk);
      chk("instr_addr", r.tag, instr_addr, r.pc);
      chk("acc",        r.tag, acc, r.acc);
      chk("cy_flag",    r.tag, {7'd0, cy_flag}, {7'd0, r.cy});
      chk("halted",     r.tag, {7'd0, halted}, {7'd0, r.hlt});
      chk("alu_op",     r.tag, {5'd0, alu_op}, {5'd0, r.op});
      chk("alu_a",      r.tag, alu_a, r.a);
      chk("alu_b",      r.tag, alu_b, r.b);
      busy = (q.size() != 0);
    end
  end

  // Reset, run the model for up to n instructions, then wait for the monitor to drain.
  task automatic run_prog(input string name, input int n, input int extra);
    logic [7:0]  pc, ac, a, b, nxt, imm;
    logic [7:0]  r [4];
    logic [2:0]  op;
    logic [15:0] ins;
    logic [8:0]  res;
    logic        cy, halt_now;
    int          wt, t, cnt;
    @(posedge clk); #2;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) push(1, -1, 8'd0, 8'd0, 1'b0, 1'b0, 3'd0, 8'd0, 8'd0);
    pc = 0; ac = 0; cy = 0; op = 0; a = 0; b = 0; wt = 1; cnt = 0;
    for (int i = 0; i < 4; i++) r[i] = 8'd0;
    for (int k = 0; k < n; k++) begin
      push(wt, k, pc, ac, cy, 1'b0, op, a, b);
      cnt++;
      ins = rom[pc]; imm = ins[7:0]; nxt = pc + 8'd1; wt = 3; halt_now = 1'b0;
      case (ins[15:12])
        4'h1: ac = imm;
        4'h2: r[ins[9:8]] = ac;
        4'h3: nxt = imm;
        4'h4: if (cy) nxt = imm;
        4'h5: if (ac == 8'd0) nxt = imm;
        4'h6: halt_now = 1'b1;
        default: ;
      endcase
      if (ins[15]) begin
        op = ins[14:12]; a = ac; b = ins[11] ? r[ins[9:8]] : imm;
        res = alu_f(op, a, b);
        ac = res[7:0];
        if (op == 3'd0) cy = res[8];
        else if (op >= 3'd2 && op <= 3'd5) cy = 1'b0;
        wt = 4;
      end
      pc = nxt;
      if (halt_now) begin
        push(3, k, pc, ac, cy, 1'b1, op, a, b);
        for (int h = 0; h < 19; h++) push(1, k, pc, ac, cy, 1'b1, op, a, b);
        break;
      end
    end
    -> pushed_ev;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    t = 0;
    while (!(q.size() == 0 && !busy) && t < 5000) begin
      @(posedge clk);
      t++;
    end
    n_checks++;
    if (t >= 5000) begin
      $display("FAIL timeout run %s: got pending %0d expected 0", name, q.size());
      q.delete();
    end else n_pass++;
    $display("run %s: %0d instructions modelled, reset lands %0d cycles later", name, cnt, extra);
    repeat (extra) @(posedge clk);
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 256; i++) rom[i] = 16'h0000;
  endtask

  initial begin
    logic [15:0] w;
    clear_rom();
    repeat (2) @(posedge clk);

    rom[0] = 16'h100A; rom[1] = 16'h8002; rom[2] = 16'h10FF; rom[3] = 16'h8001;
    rom[4] = 16'h4010; rom[16] = 16'h6000;
    run_prog("add_jc", 10, 0);

    clear_rom();
    rom[0] = 16'h10FF; rom[1] = 16'h8001; rom[2] = 16'h100A; rom[3] = 16'h9002; rom[4] = 16'h6000;
    run_prog("sub_keeps_cy", 10, 0);

    clear_rom();
    rom[0] = 16'h10F0; rom[1] = 16'h2200; rom[2] = 16'h103C; rom[3] = 16'hAA00; rom[4] = 16'h6000;
    run_prog("reg_and", 10, 0);

    clear_rom();
    rom[0] = 16'h30FF;
    run_prog("pc_wrap", 6, 0);

    clear_rom();
    rom[0] = 16'h1000; rom[1] = 16'h5020;
    rom[32] = 16'h1001; rom[33] = 16'h5030; rom[34] = 16'h6000; rom[48] = 16'h6000;
    run_prog("jz", 10, 0);

    // Stop after the ADD fetch; the next reset lands in its WB cycle.
    clear_rom();
    rom[0] = 16'h1005; rom[1] = 16'h8003; rom[2] = 16'h6000;
    run_prog("add_then_reset", 2, 1);
    run_prog("restart", 10, 0);

    for (int p = 0; p < 6; p++) begin
      for (int i = 0; i < 256; i++) begin
        w = 16'($urandom);
        if (w[15:12] == 4'h6 && $urandom_range(3) != 0) w[15:12] = 4'h8;
        rom[i] = w;
      end
      run_prog($sformatf("random%0d", p), 40, $urandom_range(3));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
